// File: rtl/rc6_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rc6_key_ctrl
// Description : Two-requester RC6 key-load controller. Arbitrates key-load
//               requests round-robin, skips expansion when the requested key
//               is already expanded, and otherwise strobes the key-expansion
//               engine and waits for it to report ready.
//               Optional feature macro: RC6_KEYCTL_TIMEOUT_EN adds a WAIT
//               cycle limit (KX_TIMEOUT) that aborts with an o_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rc6_key_ctrl #(
    parameter int KX_TIMEOUT = 160
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [1:0]   i_req,
    input  logic [127:0] i_key0,
    input  logic [127:0] i_key1,
    input  logic         i_cipher_busy,
    output logic [1:0]   o_gnt,
    output logic [1:0]   o_done,
    output logic [127:0] o_kx_key,
    output logic         o_kx_en,
    input  logic         i_kx_ok,
    output logic         o_key_valid,
    output logic         o_sel,
    output logic         o_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_HIT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t         state;
    logic [127:0]   stored_key;   // key whose expansion is (or was) in the engine
    logic [127:0]   grant_key;    // key captured with the current grant
    logic           cur_sel;      // requester owning the current transaction
    logic           prio;         // requester that wins a simultaneous request

    logic           pick;
    logic [127:0]   pick_key;
    logic           hit;
    logic           can_grant;

`ifdef RC6_KEYCTL_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(KX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KX_TIMEOUT - 1);
    logic [CNT_W-1:0]            wait_cnt;
`else
    assign o_err = 1'b0;
`endif

    // Round-robin pick of the requester and hit detection against the stored key
    always_comb begin
        pick = prio;
        if (i_req == 2'b01) begin
            pick = 1'b0;
        end else if (i_req == 2'b10) begin
            pick = 1'b1;
        end
        pick_key  = pick ? i_key1 : i_key0;
        hit       = o_key_valid && (pick_key == stored_key);
        can_grant = (i_req != 2'b00) && !i_cipher_busy;
    end

    // Controller FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            o_gnt       <= 2'b00;
            o_done      <= 2'b00;
            o_kx_en     <= 1'b0;
            o_kx_key    <= '0;
            o_key_valid <= 1'b0;
            o_sel       <= 1'b0;
            stored_key  <= '0;
            grant_key   <= '0;
            cur_sel     <= 1'b0;
            prio        <= 1'b0;
`ifdef RC6_KEYCTL_TIMEOUT_EN
            o_err       <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            o_gnt   <= 2'b00;
            o_done  <= 2'b00;
            o_kx_en <= 1'b0;
`ifdef RC6_KEYCTL_TIMEOUT_EN
            o_err   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (can_grant) begin
                        o_gnt     <= pick ? 2'b10 : 2'b01;
                        cur_sel   <= pick;
                        grant_key <= pick_key;
                        state     <= hit ? ST_HIT : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    o_kx_key    <= grant_key;
                    o_kx_en     <= 1'b1;
                    o_key_valid <= 1'b0;
`ifdef RC6_KEYCTL_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // o_kx_en is still high in the first WAIT cycle, so a stale
                    // ready level from the previous key is ignored there
                    if (i_kx_ok && !o_kx_en) begin
                        o_done      <= {cur_sel, ~cur_sel};
                        o_key_valid <= 1'b1;
                        stored_key  <= grant_key;
                        o_sel       <= cur_sel;
                        prio        <= ~cur_sel;
                        state       <= ST_DONE;
                    end
`ifdef RC6_KEYCTL_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        o_err      <= 1'b1;
                        stored_key <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_HIT: begin
                    o_done <= {cur_sel, ~cur_sel};
                    o_sel  <= cur_sel;
                    prio   <= ~cur_sel;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rc6_key_ctrl.md
RC6_KEY_CTRL -- requirements
Module: rc6_key_ctrl

Interface
REQ-001 SHALL have parameter KX_TIMEOUT, default 160, the WAIT-state cycle limit used only when RC6_KEYCTL_TIMEOUT_EN is defined.
REQ-002 SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 SHALL have port i_req, input, 2 bits, level key-load request per requester; held until granted.
REQ-005 SHALL have ports i_key0 and i_key1, input, 128 bits each, the key of requester 0 and requester 1.
REQ-006 SHALL have port i_cipher_busy, input, 1 bit; high means the cipher datapath is consuming the round keys.
REQ-007 SHALL have port o_gnt, output, 2 bits, a one-hot one-cycle pulse accepting a request.
REQ-008 SHALL have port o_done, output, 2 bits, a one-hot one-cycle pulse meaning the granted requester's round keys are ready.
REQ-009 SHALL have port o_kx_key, output, 128 bits, the key driven to the expansion engine.
REQ-010 SHALL have port o_kx_en, output, 1 bit, the one-cycle key-init strobe to the expansion engine.
REQ-011 SHALL have port i_kx_ok, input, 1 bit, the engine's key-ready level.
REQ-012 SHALL have port o_key_valid, output, 1 bit, high while the expanded keys match the stored key.
REQ-013 SHALL have port o_sel, output, 1 bit, the requester whose key was last loaded.
REQ-014 SHALL have port o_err, output, 1 bit, a one-cycle pulse on expansion timeout.

Function
REQ-015 SHALL implement the states IDLE, LOAD, WAIT, HIT and DONE; the controller leaves IDLE only on a grant.
REQ-016 In IDLE with i_req nonzero and i_cipher_busy low, SHALL issue o_gnt for one cycle and sample the granted key in that cycle; no grant SHALL be issued while i_cipher_busy is high.
REQ-017 SHALL arbitrate round-robin: with both requests set, the requester not granted last wins; after reset requester 0 has priority.
REQ-018 If the granted key equals the stored key and o_key_valid is 1, SHALL go to HIT and pulse o_done[sel] on the next cycle without strobing the engine (grant-to-done latency 1).
REQ-019 Otherwise SHALL go to LOAD: drive o_kx_key with the granted key and assert o_kx_en for exactly one cycle, clearing o_key_valid in that same cycle.
REQ-020 In WAIT SHALL ignore i_kx_ok during the o_kx_en cycle; on the first later cycle with i_kx_ok high it SHALL go to DONE.
REQ-021 In DONE SHALL pulse o_done[sel], set o_key_valid, store the key, update o_sel and the round-robin pointer, then return to IDLE.
REQ-022 o_kx_key SHALL hold its value from LOAD until the next LOAD.
REQ-023 Request changes during LOAD, WAIT, HIT or DONE SHALL be ignored; a request dropped before its grant SHALL be lost silently.
REQ-024 SHALL never assert o_gnt and o_done in the same cycle, and SHALL set at most one bit of each.

Reset
REQ-025 i_rst_n low SHALL asynchronously force IDLE, with o_gnt=0, o_done=0, o_kx_en=0, o_kx_key=0, o_key_valid=0, o_sel=0, o_err=0, the stored key to 0, and the priority pointer to requester 0, including mid-WAIT.
REQ-026 The first grant after reset SHALL always take the LOAD path, because o_key_valid is 0.

Configuration
REQ-027 With RC6_KEYCTL_TIMEOUT_EN defined, a counter SHALL count WAIT cycles, and reaching KX_TIMEOUT without i_kx_ok SHALL pulse o_err, keep o_key_valid 0, clear the stored key, omit o_done and return to IDLE.
REQ-028 Without RC6_KEYCTL_TIMEOUT_EN, WAIT SHALL wait indefinitely, o_err SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-029 Reset, then i_req=01 with key K1 -> o_gnt=01 and o_kx_en pulse carrying K1; engine ok 132 cycles later -> o_done=01 one cycle, o_key_valid=1, o_sel=0.
REQ-030 Repeat the request with the same K1 -> o_done=01 one cycle after o_gnt, and no o_kx_en pulse.
REQ-031 i_req=11 after the last grant went to requester 0 -> o_gnt=10 first; after its done, o_gnt=01.
REQ-032 i_cipher_busy=1 with i_req=01 for 50 cycles -> no o_gnt; busy falls -> o_gnt=01 the next cycle.
REQ-033 i_rst_n pulsed low during WAIT -> all outputs return to reset values immediately; a later same-key request -> LOAD path taken.
REQ-034 With RC6_KEYCTL_TIMEOUT_EN defined and i_kx_ok tied 0 -> o_err pulse exactly 160 WAIT cycles after o_kx_en, no o_done, and return to IDLE.
